// File: rtl/rgb_pwm_generator.sv
// rgb_pwm_generator
// Three-channel PWM generator for the RGB LED. Each channel takes a percent
// duty command (0..100; larger values clamp to 100). A period is
// 100*STEP_CYCLES clocks long. New duty triples are loaded through a
// valid/ready handshake and take effect only at period boundaries.
//
// Ports:
//   clock         system clock
//   reset         synchronous, active-low reset
//   enable        1 = generate PWM, 0 = idle with outputs low
//   duty_valid    a new duty triple is offered
//   duty_ready    a triple can be accepted (no update pending), registered
//   red_duty      red duty, percent
//   green_duty    green duty, percent
//   blue_duty     blue duty, percent
//   pwm_red       red PWM output, registered
//   pwm_green     green PWM output, registered
//   pwm_blue      blue PWM output, registered
//   period_start  one-cycle pulse on the first output cycle of each period
module rgb_pwm_generator #(
  parameter int unsigned STEP_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       duty_valid,
  output logic       duty_ready,
  input  logic [7:0] red_duty,
  input  logic [7:0] green_duty,
  input  logic [7:0] blue_duty,
  output logic       pwm_red,
  output logic       pwm_green,
  output logic       pwm_blue,
  output logic       period_start
);

  localparam int unsigned STEP_W     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned PHASE_W    = 7;
  localparam int unsigned DUTY_IN_W  = 8;
  localparam int unsigned PHASE_LAST = 99;
  localparam int unsigned DUTY_MAX   = 100;

  localparam logic [STEP_W-1:0]  STEP_LAST_V  = STEP_W'(STEP_CYCLES - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST_V = PHASE_W'(PHASE_LAST);

  // Clamped duty triple; 7 bits is enough because every value is <= 100.
  typedef struct packed {
    logic [PHASE_W-1:0] red;
    logic [PHASE_W-1:0] green;
    logic [PHASE_W-1:0] blue;
  } duty_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [STEP_W-1:0]  step_cnt;
  logic [PHASE_W-1:0] phase;
  duty_t              active_q;
  duty_t              pending_q;
  duty_t              capture_c;
  logic               step_wrap_c;
  logic               boundary_c;
  logic               transfer_c;
  logic               apply_c;
  logic               run_c;

  // Saturate an 8-bit percent command at 100.
  function automatic logic [PHASE_W-1:0] clamp_duty(input logic [DUTY_IN_W-1:0] d);
    logic [PHASE_W-1:0] r;
    if (d > DUTY_IN_W'(DUTY_MAX)) begin
      r = PHASE_W'(DUTY_MAX);
    end else begin
      r = d[PHASE_W-1:0];
    end
    return r;
  endfunction

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: enable is followed immediately in both directions.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable)  state_d = RUN;
      RUN:     if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control decodes shared by the counter, duty and output registers.
  always_comb begin
    run_c       = (state_q == RUN);
    step_wrap_c = (step_cnt == STEP_LAST_V);
    boundary_c  = run_c && step_wrap_c && (phase == PHASE_LAST_V);
    transfer_c  = duty_valid && duty_ready;
    // Idle applies a pending update right away; running waits for the boundary.
    apply_c     = !duty_ready && (run_c ? boundary_c : 1'b1);
    capture_c.red   = clamp_duty(red_duty);
    capture_c.green = clamp_duty(green_duty);
    capture_c.blue  = clamp_duty(blue_duty);
  end

  // Step and phase counters; held at zero outside RUN and cleared on leaving it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      step_cnt <= '0;
      phase    <= '0;
    end else if (!run_c || (state_d != RUN)) begin
      step_cnt <= '0;
      phase    <= '0;
    end else if (step_wrap_c) begin
      step_cnt <= '0;
      if (phase == PHASE_LAST_V) begin
        phase <= '0;
      end else begin
        phase <= phase + PHASE_W'(1);
      end
    end else begin
      step_cnt <= step_cnt + STEP_W'(1);
    end
  end

  // Duty staging: a transfer fills pending, an apply moves it to active.
  // transfer_c needs duty_ready=1 and apply_c needs duty_ready=0, so they
  // never coincide; a transfer on the boundary cycle waits a full period.
  always_ff @(posedge clock) begin
    if (!reset) begin
      active_q   <= '0;
      pending_q  <= '0;
      duty_ready <= 1'b1;
    end else begin
      if (apply_c) begin
        active_q <= pending_q;
      end
      if (transfer_c) begin
        pending_q  <= capture_c;
        duty_ready <= 1'b0;
      end else if (apply_c) begin
        duty_ready <= 1'b1;
      end
    end
  end

  // Output compare; outputs lag the counters by one cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pwm_red      <= 1'b0;
      pwm_green    <= 1'b0;
      pwm_blue     <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pwm_red      <= run_c && (phase < active_q.red);
      pwm_green    <= run_c && (phase < active_q.green);
      pwm_blue     <= run_c && (phase < active_q.blue);
      period_start <= run_c && (step_cnt == '0) && (phase == '0);
    end
  end

endmodule

// File: tb/tb_rgb_pwm_generator.sv
// Directed bench for rgb_pwm_generator with STEP_CYCLES=4 (400-cycle period).
module tb_rgb_pwm_generator;

  localparam int unsigned STEP = 4;
  localparam int PERIOD = 100 * STEP;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       duty_valid;
  logic       duty_ready;
  logic [7:0] red_duty;
  logic [7:0] green_duty;
  logic [7:0] blue_duty;
  logic       pwm_red;
  logic       pwm_green;
  logic       pwm_blue;
  logic       period_start;

  int total = 0;
  int bad   = 0;

  // Results of the most recent measure() call.
  int m_r, m_g, m_b, m_ps, m_rdy_low, m_rdy_end, m_acc1, m_acc2;

  rgb_pwm_generator #(.STEP_CYCLES(STEP)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .red_duty     (red_duty),
    .green_duty   (green_duty),
    .blue_duty    (blue_duty),
    .pwm_red      (pwm_red),
    .pwm_green    (pwm_green),
    .pwm_blue     (pwm_blue),
    .period_start (period_start)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int r, input int g, input int b);
    red_duty   = 8'(r);
    green_duty = 8'(g);
    blue_duty  = 8'(b);
  endtask

  // Waits for period_start, then samples one full period while optionally
  // offering up to two triples (second one held until accepted).
  // Leaves the bench on the first cycle of the following period.
  task automatic measure(input int off1, input int r1, input int g1, input int b1,
                         input int off2, input int v2);
    int  n_sent;
    int  wait_cnt;
    bit  xfer;
    m_r = 0; m_g = 0; m_b = 0; m_ps = 0; m_rdy_low = 0; m_rdy_end = -1;
    m_acc1 = -1; m_acc2 = -1;
    n_sent = 0;
    wait_cnt = 0;
    while (!period_start && wait_cnt < 1000) begin
      tick();
      wait_cnt++;
    end
    if (!period_start) begin
      check("period_start_timeout", 0, 1);
      return;
    end
    for (int i = 0; i < PERIOD; i++) begin
      m_r  += int'(pwm_red);
      m_g  += int'(pwm_green);
      m_b  += int'(pwm_blue);
      m_ps += int'(period_start);
      if (!duty_ready) m_rdy_low++;
      if (i == PERIOD - 1) m_rdy_end = int'(duty_ready);
      if (n_sent == 0 && i == off1) begin
        drive(r1, g1, b1);
        duty_valid = 1'b1;
      end
      if (n_sent == 1 && off2 >= 0 && i >= off2 && !duty_valid) begin
        drive(v2, v2, v2);
        duty_valid = 1'b1;
      end
      xfer = duty_valid && duty_ready;
      tick();
      if (xfer) begin
        if (n_sent == 0) m_acc1 = i;
        else             m_acc2 = i;
        n_sent++;
        duty_valid = 1'b0;
      end
    end
    duty_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; duty_valid = 1'b0;
    drive(0, 0, 0);
    repeat (3) tick();
    check("rst_pwm_red", int'(pwm_red), 0);
    check("rst_pwm_green", int'(pwm_green), 0);
    check("rst_pwm_blue", int'(pwm_blue), 0);
    check("rst_period_start", int'(period_start), 0);
    check("rst_duty_ready", int'(duty_ready), 1);
    reset = 1'b1;
    tick();

    // Load while idle: ready drops for one cycle, then the update is applied.
    drive(25, 50, 75);
    duty_valid = 1'b1;
    tick();
    duty_valid = 1'b0;
    check("idle_load_ready_low", int'(duty_ready), 0);
    tick();
    check("idle_load_ready_back", int'(duty_ready), 1);

    // Start: first period_start and high cycle two cycles after enable sampled.
    enable = 1'b1;
    tick();
    check("start_k1_ps", int'(period_start), 0);
    check("start_k1_red", int'(pwm_red), 0);
    tick();
    check("start_k2_ps", int'(period_start), 1);
    check("start_k2_red", int'(pwm_red), 1);

    // Basic waveform 25/50/75.
    for (int p = 0; p < 2; p++) begin
      measure(-1, 0, 0, 0, -1, 0);
      check("basic_red_high", m_r, 100);
      check("basic_green_high", m_g, 200);
      check("basic_blue_high", m_b, 300);
      check("basic_ps_count", m_ps, 1);
    end

    // Extremes and clamp: load (0,100,200) during a 25/50/75 period.
    measure(0, 0, 100, 200, -1, 0);
    check("ext_load_acc", m_acc1, 0);
    check("ext_old_red", m_r, 100);
    for (int p = 0; p < 3; p++) begin
      measure(-1, 0, 0, 0, -1, 0);
      check("ext_red_low", m_r, 0);
      check("ext_green_high", m_g, PERIOD);
      check("ext_blue_clamped", m_b, PERIOD);
      check("ext_ps_count", m_ps, 1);
    end

    // Mid-period update: 50 % running, offer 10 % at cycle 120.
    measure(0, 50, 50, 50, -1, 0);
    check("mid_prev_green", m_g, PERIOD);
    measure(120, 10, 10, 10, -1, 0);
    check("mid_acc", m_acc1, 120);
    check("mid_cur_red", m_r, 200);
    check("mid_ready_low_cycles", m_rdy_low, 278);
    check("mid_ready_end", m_rdy_end, 1);
    measure(-1, 0, 0, 0, -1, 0);
    check("mid_next_red", m_r, 40);
    check("mid_next_blue", m_b, 40);

    // Back-pressure: second triple held until ready rises, applied a period later.
    measure(10, 30, 30, 30, 20, 60);
    check("bp_acc1", m_acc1, 10);
    check("bp_acc2", m_acc2, PERIOD - 1);
    check("bp_cur_red", m_r, 40);
    measure(-1, 0, 0, 0, -1, 0);
    check("bp_first_red", m_r, 120);
    // Transfer on the boundary cycle itself.
    measure(PERIOD - 2, 5, 5, 5, -1, 0);
    check("bp_second_red", m_r, 240);
    check("coll_acc", m_acc1, PERIOD - 2);
    measure(-1, 0, 0, 0, -1, 0);
    check("coll_not_yet_red", m_r, 240);
    measure(-1, 0, 0, 0, -1, 0);
    check("coll_applied_red", m_r, 20);

    // Enable toggling at cycle 50 of a 25 % red period.
    measure(0, 25, 25, 25, -1, 0);
    measure(-1, 0, 0, 0, -1, 0);
    check("tog_red_high", m_r, 100);
    repeat (50) tick();
    enable = 1'b0;
    tick();
    check("tog_red_last_run_cycle", int'(pwm_red), 1);
    tick();
    check("tog_red_low", int'(pwm_red), 0);
    repeat (3) tick();
    check("tog_red_still_low", int'(pwm_red), 0);
    check("tog_ps_low", int'(period_start), 0);
    drive(40, 40, 40);
    duty_valid = 1'b1;
    tick();
    duty_valid = 1'b0;
    check("tog_idle_ready_low", int'(duty_ready), 0);
    tick();
    check("tog_idle_ready_back", int'(duty_ready), 1);
    enable = 1'b1;
    tick();
    check("reen_k1_ps", int'(period_start), 0);
    tick();
    check("reen_k2_ps", int'(period_start), 1);
    check("reen_k2_red", int'(pwm_red), 1);
    // Loopback-style on-time reading, twice for stability.
    for (int p = 0; p < 2; p++) begin
      measure(-1, 0, 0, 0, -1, 0);
      check("loop_red_40pct", m_r, 160);
    end

    // Reset mid-period with an update pending.
    repeat (5) tick();
    drive(90, 90, 90);
    duty_valid = 1'b1;
    tick();
    duty_valid = 1'b0;
    check("rstmid_pending", int'(duty_ready), 0);
    repeat (94) tick();
    reset = 1'b0;
    tick();
    check("rstmid_red", int'(pwm_red), 0);
    check("rstmid_green", int'(pwm_green), 0);
    check("rstmid_blue", int'(pwm_blue), 0);
    check("rstmid_ps", int'(period_start), 0);
    check("rstmid_ready", int'(duty_ready), 1);
    repeat (2) tick();
    reset = 1'b1;
    for (int p = 0; p < 2; p++) begin
      measure(-1, 0, 0, 0, -1, 0);
      check("post_rst_red", m_r, 0);
      check("post_rst_green", m_g, 0);
      check("post_rst_blue", m_b, 0);
      check("post_rst_ps", m_ps, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_generator.md
# rgb_pwm_generator

Three-channel PWM generator driving the red, green and blue pins of the RGB LED from 8-bit percent duty-cycle commands. It is the transmit-side counterpart of the per-colour PWM duty-cycle detectors, and its output can be looped back into them for self-test. New duty values are loaded through a valid/ready handshake. They are applied only at period boundaries, so a period is never glitched mid-cycle.

## Interface
- STEP_CYCLES, 1000, clock cycles per 1 % step; period = 100*STEP_CYCLES cycles; legal range ≥1
- clock  in  1  system clock
- reset  in  1  synchronous, active-low
- enable  in  1  1 = generate PWM, 0 = idle (outputs low)
- duty_valid  in  1  new duty triple offered
- duty_ready  out  1  block can accept a triple (= no update pending)
- red_duty  in  8  red duty, percent
- green_duty  in  8  green duty, percent
- blue_duty  in  8  blue duty, percent
- pwm_red  out  1  red PWM output, registered
- pwm_green  out  1  green PWM output, registered
- pwm_blue  out  1  blue PWM output, registered
- period_start  out  1  one-cycle pulse aligned with the first output cycle of each period

## Operation
- **Reset** (reset=0 at a clock edge):
  - State IDLE; step_cnt=0 and phase=0.
  - active and pending duties = 0; pending flag = 0.
  - pwm_* = 0 and period_start = 0.
  - duty_ready reads 1 out of reset.
- **Counters:**
  - step_cnt is $clog2(STEP_CYCLES) bits wide (minimum 1 bit) and counts 0..STEP_CYCLES-1.
  - On each step_cnt wrap, phase (7 bits) advances 0..99 and then wraps to 0.
  - The boundary is step_cnt==STEP_CYCLES-1 && phase==99.
- **Compare:** pwm_x <= (state==RUN) && (phase < active_x). There is no width extension issue because active_x ≤ 100.
  - duty 0 → output constantly low.
  - duty 100 → output constantly high, with no low cycle across periods.
- **Clamp:** inputs above 100 are clamped to 100 when captured.
- **Handshake:**
  - Transfer occurs on a cycle with duty_valid && duty_ready; the three clamped values are captured into pending and the pending flag is set.
  - duty_ready = !pending.
  - While duty_ready=0, duty_valid is ignored. The source must hold its data; the block does not drop transfers silently.
- **Apply:**
  - In RUN, if pending is set at a boundary edge: active <= pending and the flag is cleared on that same edge.
  - In IDLE, a set pending flag is applied on the next edge.
  - A transfer accepted on the boundary cycle itself is applied at the following boundary. There is no bypass.
- **States:**
  - IDLE → RUN when enable=1 is sampled; step_cnt and phase start at 0 on the next cycle.
  - RUN → IDLE when enable=0 is sampled. The transition is immediate: counters clear, and pwm_* go low one cycle later. There is no wait for the period end.
  - A pending update is kept across RUN → IDLE and then applied in IDLE.
- **Reset mid-operation:** all state is discarded, including any pending update. duty_ready returns to 1.

## Timing
- Outputs lag the counters by one cycle:
  - enable sampled high at edge k.
  - Counters are (0,0) during cycle k+1.
  - period_start=1 and the first PWM cycle occur in cycle k+2.
- **High time:** exactly active_x*STEP_CYCLES cycles per period, followed by (100-active_x)*STEP_CYCLES low cycles.
- **period_start:** registered; 1 for exactly one cycle every 100*STEP_CYCLES cycles while RUN persists.
- **Update latency:** a new duty first appears on the pwm_* cycle that carries period_start.
- duty_ready rises in the cycle after the apply edge.
- **STEP_CYCLES=1:** step_cnt is constant 0 and phase advances every cycle; all rules above still hold.

## Test plan
- **Basic waveform:** STEP_CYCLES=4, load (25,50,75), enable=1.
  - Red is high 100 / low 300 cycles; green 200/200; blue 300/100.
  - period_start fires every 400 cycles, aligned with the rising edges.
- **Extremes and clamp:** load (0,100,200).
  - Red stays low and green stays high continuously over 3 periods.
  - Blue behaves as 100 (constant high); period_start continues.
- **Mid-period update:** running at (50,50,50), offer (10,10,10) at cycle 120 of a period.
  - Accepted, and duty_ready drops; the current period stays 200 high.
  - The next period is 40 high; duty_ready returns to 1 one cycle after the boundary.
- **Back-pressure and boundary collision:** offer a second triple while pending, holding duty_valid.
  - It is accepted only after duty_ready rises, and applied one period later.
  - A transfer landing exactly on the boundary cycle is applied at the next boundary.
- **Enable toggling:**
  - Deassert enable at cycle 50 of a 25 % red period: pwm_red is low from the next cycle and counters are 0.
  - A load made while idle applies within 1 cycle.
  - Re-enable: first period_start and high cycle occur 2 cycles after enable is sampled.
- **Reset mid-period with pending:** assert reset.
  - All outputs 0 and duty_ready=1; the pending triple is discarded.
  - After release plus enable, outputs stay low (active=0).
- **Loopback:** feed pwm_red into the red detector with STEP_CYCLES=4 and red=40; the detector reports a stable reading matching 40 % on-time.
